fifo_line_reader: RTL and testbench

Single-clock consumer for the read side of the async `fifo`. It pops words from the FIFO's show-ahead read port (`rd_data`, `rd_empty`, `rd_oe`) and re-times them as a valid/ready stream framed into fixed-length lines and frames. It inserts a programmable blanking gap between lines. It sits between the pixel FIFO and the downstream packet/serializer stage.

---
 rtl/fifo_line_reader.sv | 131 +++++++++++++
 tb/tb_fifo_line_reader.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_line_reader.sv
// Reads a show-ahead FIFO and re-times its words into a valid/ready stream framed
// into lines and frames, with a fixed blanking gap between the lines of a frame.
module fifo_line_reader #(
  parameter int DATA_BITS   = 24,
  parameter int LINE_WORDS  = 480,
  parameter int FRAME_LINES = 800,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [DATA_BITS-1:0] fifo_data,
  input  logic                 fifo_empty,
  output logic                 fifo_oe,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sof,
  output logic                 out_eof,
  output logic                 out_sol,
  output logic                 out_eol,
  output logic                 starved,
  output logic                 busy
);

  localparam int WW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int LW = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [WW-1:0] WORD_LAST = WW'(LINE_WORDS - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(FRAME_LINES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LINE = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [WW-1:0]   word_cnt;
  logic [LW-1:0]   line_cnt;
  logic [GW-1:0]   gap_cnt;
  logic            slot_free;
  logic            word_last;
  logic            line_last;
  logic            gap_done;

  // The output register can take a word when empty or being drained this cycle.
  assign slot_free = !out_valid || out_ready;
  assign word_last = (word_cnt == WORD_LAST);
  assign line_last = (line_cnt == LINE_LAST);
  assign gap_done  = (gap_cnt == GAP_LAST);
  assign busy      = (state != IDLE) || out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fifo_oe   = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = LINE;
      end
      LINE: begin
        fifo_oe = !fifo_empty && slot_free;
        if (fifo_oe && word_last) begin
          if (line_last)           state_nxt = IDLE;
          else if (GAP_CYCLES > 0) state_nxt = GAP;
          else                     state_nxt = LINE;
        end
      end
      GAP: begin
        if (gap_done) state_nxt = LINE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Position counters; IDLE parks them at the start of a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt <= '0;
      line_cnt <= '0;
      gap_cnt  <= '0;
    end else if (state == IDLE) begin
      word_cnt <= '0;
      line_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      if (fifo_oe) begin
        word_cnt <= word_last ? '0 : word_cnt + 1'b1;
        if (word_last) line_cnt <= line_last ? '0 : line_cnt + 1'b1;
      end
      if (state == GAP) gap_cnt <= gap_done ? '0 : gap_cnt + 1'b1;
    end
  end

  // Output stage: data and framing flags load together and hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_sol   <= 1'b0;
      out_eol   <= 1'b0;
      starved   <= 1'b0;
    end else begin
      starved <= (state == LINE) && fifo_empty && slot_free;
      if (fifo_oe) begin
        out_data  <= fifo_data;
        out_valid <= 1'b1;
        out_sol   <= (word_cnt == '0);
        out_eol   <= word_last;
        out_sof   <= (word_cnt == '0) && (line_cnt == '0);
        out_eof   <= word_last && line_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_line_reader.sv
// Bench for fifo_line_reader: a gapped (GAP_CYCLES=2) and a gapless (GAP_CYCLES=0)
// instance fed from queue-modelled FIFOs, checked by a cycle table and a stream scoreboard.
module tb_fifo_line_reader;
  localparam int DW = 8;
  localparam int LW = 4;
  localparam int FL = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          en [2];
  logic          rdy[2];
  logic          fe [2];
  logic          oe [2];
  logic          ov [2];
  logic          sof[2];
  logic          eof[2];
  logic          sol[2];
  logic          eol[2];
  logic          stv[2];
  logic          bsy[2];
  logic [DW-1:0] fd [2];
  logic [DW-1:0] od [2];

  fifo_line_reader #(.DATA_BITS(DW), .LINE_WORDS(LW), .FRAME_LINES(FL), .GAP_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .enable(en[0]), .fifo_data(fd[0]), .fifo_empty(fe[0]),
    .fifo_oe(oe[0]), .out_data(od[0]), .out_valid(ov[0]), .out_ready(rdy[0]),
    .out_sof(sof[0]), .out_eof(eof[0]), .out_sol(sol[0]), .out_eol(eol[0]),
    .starved(stv[0]), .busy(bsy[0]));

  fifo_line_reader #(.DATA_BITS(DW), .LINE_WORDS(LW), .FRAME_LINES(FL), .GAP_CYCLES(0)) dut_ng (
    .clk(clk), .rst(rst), .enable(en[1]), .fifo_data(fd[1]), .fifo_empty(fe[1]),
    .fifo_oe(oe[1]), .out_data(od[1]), .out_valid(ov[1]), .out_ready(rdy[1]),
    .out_sof(sof[1]), .out_eof(eof[1]), .out_sol(sol[1]), .out_eol(eol[1]),
    .starved(stv[1]), .busy(bsy[1]));

  // FIFO contents (q*), words still owed downstream (x*), pop cycle stamps (pc*).
  logic [DW-1:0] q0[$], q1[$], x0[$], x1[$];
  int            pc0[$], pc1[$];
  int            n_cmp, n_bad, cyc_n;
  int            bidx[2];
  logic          hold[2];
  logic [DW-1:0] hd[2];
  logic [3:0]    hf[2];
  logic          oep[2];
  int            t, cnt, rem;
  logic [DW-1:0] w;

  typedef struct {
    logic       en;
    logic       rdy;
    logic       oe;
    logic       v;
    logic [7:0] d;
    logic [3:0] f;
    logic       busy;
  } vec_t;
  vec_t tbl[13];

  function automatic vec_t mk(logic e, logic r, logic o, logic v, logic [7:0] d,
                              logic [3:0] f, logic b);
    vec_t x;
    x.en = e; x.rdy = r; x.oe = o; x.v = v; x.d = d; x.f = f; x.busy = b;
    return x;
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endfunction

  // Framing from the beat's position in the accepted stream: {sof,eof,sol,eol}.
  function automatic logic [3:0] flags_exp(int b);
    int pos;
    pos = b % (LW * FL);
    return {pos == 0, pos == LW * FL - 1, (pos % LW) == 0, (pos % LW) == LW - 1};
  endfunction

  function automatic void refresh();
    fe[0] = (q0.size() == 0);
    fd[0] = fe[0] ? '0 : q0[0];
    fe[1] = (q1.size() == 0);
    fd[1] = fe[1] ? '0 : q1[0];
  endfunction

  function automatic void push(int i, logic [DW-1:0] v);
    if (i == 0) begin q0.push_back(v); x0.push_back(v); end
    else        begin q1.push_back(v); x1.push_back(v); end
  endfunction

  function automatic void monitor(int i);
    logic [3:0]    f;
    logic [DW-1:0] e;
    logic          has;
    f = {sof[i], eof[i], sol[i], eol[i]};
    if (hold[i]) begin
      chk("hold_valid", ov[i], 1);
      chk("hold_data", od[i], hd[i]);
      chk("hold_flags", f, hf[i]);
    end
    if (ov[i] && !rdy[i]) begin
      chk("oe_while_stalled", oe[i], 0);
      hold[i] = 1'b1; hd[i] = od[i]; hf[i] = f;
    end else begin
      hold[i] = 1'b0;
    end
    if (ov[i] && rdy[i]) begin
      has = (i == 0) ? (x0.size() > 0) : (x1.size() > 0);
      chk("beat_expected", has, 1);
      if (has) begin
        e = (i == 0) ? x0.pop_front() : x1.pop_front();
        chk("beat_data", od[i], e);
        chk("beat_flags", f, flags_exp(bidx[i]));
      end
      bidx[i]++;
    end
  endfunction

  // One clock: check at negedge+1, FIFO pops applied just after the posedge.
  task automatic cyc();
    logic [DW-1:0] dmy;
    refresh();
    #1;
    monitor(0);
    monitor(1);
    oep[0] = oe[0];
    oep[1] = oe[1];
    @(posedge clk);
    #1;
    cyc_n++;
    if (oep[0] && q0.size() > 0) begin dmy = q0.pop_front(); pc0.push_back(cyc_n); end
    if (oep[1] && q1.size() > 0) begin dmy = q1.pop_front(); pc1.push_back(cyc_n); end
    refresh();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en[0] = 1'b0; en[1] = 1'b0; rdy[0] = 1'b1; rdy[1] = 1'b1;
    q0.delete(); q1.delete(); x0.delete(); x1.delete(); pc0.delete(); pc1.delete();
    bidx[0] = 0; bidx[1] = 0; hold[0] = 1'b0; hold[1] = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc_n = 0;
    rst = 1'b1;
    en[0] = 1'b0; en[1] = 1'b0; rdy[0] = 1'b1; rdy[1] = 1'b1;
    bidx[0] = 0; bidx[1] = 0; hold[0] = 1'b0; hold[1] = 1'b0;
    refresh();
    #2;
    chk("rst_valid", ov[0], 0);
    chk("rst_data", od[0], 0);
    chk("rst_flags", {sof[0], eof[0], sol[0], eol[0]}, 0);
    chk("rst_starved", stv[0], 0);
    chk("rst_busy", bsy[0], 0);
    chk("rst_oe", oe[0], 0);
    @(negedge clk);

    // Full frame, cycle by cycle: {en, rdy, oe, valid, data, {sof,eof,sol,eol}, busy}
    tbl[0]  = mk(1, 1, 0, 0, 8'h00, 4'b0000, 0);
    tbl[1]  = mk(1, 1, 1, 0, 8'h00, 4'b0000, 1);
    tbl[2]  = mk(1, 1, 1, 1, 8'h10, 4'b1010, 1);
    tbl[3]  = mk(0, 1, 1, 1, 8'h11, 4'b0000, 1);
    tbl[4]  = mk(0, 1, 1, 1, 8'h12, 4'b0000, 1);
    tbl[5]  = mk(0, 1, 0, 1, 8'h13, 4'b0001, 1);
    tbl[6]  = mk(0, 1, 0, 0, 8'h00, 4'b0000, 1);
    tbl[7]  = mk(0, 1, 1, 0, 8'h00, 4'b0000, 1);
    tbl[8]  = mk(0, 1, 1, 1, 8'h14, 4'b0010, 1);
    tbl[9]  = mk(0, 1, 1, 1, 8'h15, 4'b0000, 1);
    tbl[10] = mk(0, 1, 1, 1, 8'h16, 4'b0000, 1);
    tbl[11] = mk(0, 1, 0, 1, 8'h17, 4'b0101, 1);
    tbl[12] = mk(0, 1, 0, 0, 8'h00, 4'b0000, 0);
    do_reset();
    for (int i = 0; i < 8; i++) push(0, DW'(8'h10 + i));
    for (int k = 0; k < 13; k++) begin
      en[0] = tbl[k].en;
      rdy[0] = tbl[k].rdy;
      refresh();
      #1;
      chk("tbl_oe", oe[0], tbl[k].oe);
      chk("tbl_valid", ov[0], tbl[k].v);
      chk("tbl_busy", bsy[0], tbl[k].busy);
      if (tbl[k].v) begin
        chk("tbl_data", od[0], tbl[k].d);
        chk("tbl_flags", {sof[0], eof[0], sol[0], eol[0]}, tbl[k].f);
      end
      cyc();
    end
    chk("frame_pops", pc0.size(), 8);

    // Backpressure: alternating ready, then random stalls.
    do_reset();
    for (int i = 0; i < 8; i++) push(0, DW'(8'h10 + i));
    en[0] = 1'b1;
    for (int k = 0; k < 60; k++) begin
      rdy[0] = (k < 12) ? (k % 2 == 0) : ($urandom_range(0, 2) != 0);
      if (k == 2) en[0] = 1'b0;
      cyc();
    end
    rdy[0] = 1'b1;
    repeat (5) cyc();
    chk("bp_beats", bidx[0], 8);
    chk("bp_left", x0.size(), 0);

    // Starvation: two words, five empty cycles, then refill.
    do_reset();
    push(0, 8'h10); push(0, 8'h11);
    en[0] = 1'b1;
    t = 0;
    while (q0.size() != 0 && t < 20) begin cyc(); t++; end
    chk("starve_drain", q0.size(), 0);
    en[0] = 1'b0;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      cnt += int'(stv[0]);
      cyc();
    end
    chk("starved_cycles", cnt, 4);
    for (int i = 2; i < 8; i++) push(0, DW'(8'h10 + i));
    repeat (20) cyc();
    chk("starve_beats", bidx[0], 8);
    chk("starved_clear", stv[0], 0);

    // Enable pulsed for one cycle: exactly one frame.
    do_reset();
    for (int i = 0; i < 16; i++) push(0, DW'(8'h10 + i));
    en[0] = 1'b1;
    cyc();
    en[0] = 1'b0;
    repeat (40) cyc();
    chk("pulse_pops", pc0.size(), 8);
    chk("pulse_left", q0.size(), 8);
    chk("pulse_beats", bidx[0], 8);
    chk("pulse_busy", bsy[0], 0);

    // Enable held: line gap and frame boundary spacing on both instances.
    do_reset();
    for (int i = 0; i < 16; i++) begin push(0, DW'(8'h10 + i)); push(1, DW'(8'h10 + i)); end
    en[0] = 1'b1; en[1] = 1'b1;
    repeat (45) cyc();
    en[0] = 1'b0; en[1] = 1'b0;
    chk("held_pops_gap2", pc0.size(), 16);
    chk("held_pops_gap0", pc1.size(), 16);
    chk("held_beats_gap2", bidx[0], 16);
    chk("held_beats_gap0", bidx[1], 16);
    if (pc0.size() >= 9) begin
      chk("line_gap_gap2", pc0[4] - pc0[3], 3);
      chk("frame_gap_gap2", pc0[8] - pc0[7], 2);
    end
    if (pc1.size() >= 9) begin
      chk("line_gap_gap0", pc1[4] - pc1[3], 1);
      chk("frame_gap_gap0", pc1[8] - pc1[7], 2);
    end

    // Asynchronous reset mid-line.
    do_reset();
    for (int i = 0; i < 16; i++) push(0, DW'(8'h10 + i));
    en[0] = 1'b1;
    t = 0;
    while (bidx[0] < 3 && t < 30) begin cyc(); t++; end
    chk("pre_reset_beats", bidx[0], 3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", ov[0], 0);
    chk("arst_data", od[0], 0);
    chk("arst_flags", {sof[0], eof[0], sol[0], eol[0]}, 0);
    chk("arst_starved", stv[0], 0);
    chk("arst_busy", bsy[0], 0);
    chk("arst_oe", oe[0], 0);
    x0 = q0;
    rem = q0.size();
    bidx[0] = 0;
    hold[0] = 1'b0;
    #1;
    rst = 1'b0;
    @(negedge clk);
    repeat (30) cyc();
    chk("post_reset_beats", bidx[0], rem);
    chk("post_reset_left", x0.size(), 0);

    // Randomised traffic on both instances.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 2; i++) begin
        en[i]  = ($urandom_range(0, 7) != 0);
        rdy[i] = ($urandom_range(0, 3) != 0);
        w = DW'($urandom);
        if ($urandom_range(0, 2) != 0) begin
          if (i == 0 && q0.size() < 12) push(0, w);
          if (i == 1 && q1.size() < 12) push(1, w);
        end
      end
      cyc();
    end
    chk("rand_progress_gap2", bidx[0] > 500, 1);
    chk("rand_progress_gap0", bidx[1] > 500, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
